// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and widths for the multi-cycle data-memory responder
package dmem_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic int idx_width(input int depth_words);
        return $clog2(depth_words);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - word array with async clear, one write port and one registered read port
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int IDX_W       = idx_width(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              startin,
    input  logic              we,
    input  logic              re,
    input  logic [IDX_W-1:0]  addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    // Reset clears every word so a fresh run never observes stale stores.
    always_ff @(posedge clk or posedge startin) begin
        if (startin) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem[i] <= '0;
            end
            rdata <= '0;
        end else begin
            if (we) begin
                mem[addr] <= wdata;
            end
            if (re) begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - multi-cycle load/store responder with fixed latency and response backpressure
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic              clk,
    input  logic              startin,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              busy
);

    localparam int         IDX_W    = idx_width(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t            state, state_nxt;
    logic [3:0]        cnt;
    logic              lat_write;
    logic              lat_err;
    logic [IDX_W-1:0]  lat_idx;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] arr_rdata;
    logic              req_err;
    logic              accept;
    logic              wait_done;
    logic              arr_we;
    logic              arr_re;

    // Any set bit above the index field is out of range, so high addresses never alias.
    assign req_err   = (req_addr[1:0] != 2'b00) || (req_addr[ADDR_W-1:IDX_W+2] != '0);
    assign accept    = (state == ST_IDLE) && req_valid;
    assign wait_done = (state == ST_WAIT) && (cnt == 4'd0);
    assign arr_we    = wait_done && lat_write && !lat_err;
    assign arr_re    = wait_done && !lat_write && !lat_err;

    always_ff @(posedge clk or posedge startin) begin
        if (startin) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        busy       = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                busy = 1'b1;
                if (cnt == 4'd0) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                busy       = 1'b1;
                if (resp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Request fields are captured once at acceptance; later req_* changes are ignored.
    always_ff @(posedge clk or posedge startin) begin
        if (startin) begin
            cnt       <= 4'd0;
            lat_write <= 1'b0;
            lat_err   <= 1'b0;
            lat_idx   <= '0;
            lat_wdata <= '0;
        end else if (accept) begin
            cnt       <= CNT_INIT;
            lat_write <= req_write;
            lat_err   <= req_err;
            lat_idx   <= req_addr[IDX_W+1:2];
            lat_wdata <= req_wdata;
        end else if ((state == ST_WAIT) && (cnt != 4'd0)) begin
            cnt <= cnt - 4'd1;
        end
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk     (clk),
        .startin (startin),
        .we      (arr_we),
        .re      (arr_re),
        .addr    (lat_idx),
        .wdata   (lat_wdata),
        .rdata   (arr_rdata)
    );

    // The array read register keeps the last load; gate it so stores and errors return zero.
    assign resp_rdata = ((state == ST_RESP) && !lat_write && !lat_err) ? arr_rdata : '0;
    assign resp_err   = (state == ST_RESP) && lat_err;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Multi-cycle data-memory responder serving load/store requests issued by the CPU's MEM stage over a valid/ready request channel and a valid/ready response channel.
- Replaces the single-cycle data memory when modelling a slow memory. The CPU side is the initiator and this block is the responder.
- The MEM stage stalls on req_ready/resp_valid; that stall logic is outside this block.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words stored; power of two, at least 4.
- LATENCY, 2, clock edges from request acceptance to first resp_valid; range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- startin  in  1  reset, asynchronous, active-high; clears all state and memory contents.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- resp_valid  out  1  response present.
- resp_ready  in  1  initiator consumes the response.
- resp_rdata  out  32  load data; 0 for stores and errors.
- resp_err  out  1  request was misaligned or out of range.
- busy  out  1  high in WAIT or RESP; used as a stall hint.

Behaviour:
- Reset (startin high, asynchronous):
  - state = IDLE; req_ready = 1; resp_valid = 0; resp_rdata = 0; resp_err = 0; busy = 0.
  - Latency counter = 0; all DEPTH_WORDS words = 0.
- Storage: register array indexed by req_addr[log2(DEPTH_WORDS)+1:2].
- Error: req_addr[1:0] != 0, or req_addr[31:2] >= DEPTH_WORDS, sets resp_err = 1.
  - No write occurs; resp_rdata = 0.
  - Latency is identical to a good access.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready = 1. On an edge with req_valid = 1, latch write, addr, wdata and error flag; counter = LATENCY-1; go to WAIT.
  - WAIT: req_ready = 0, busy = 1. If counter != 0, decrement. If counter == 0, go to RESP at the next edge.
  - RESP: resp_valid = 1, busy = 1; resp_rdata and resp_err held stable. On an edge with resp_ready = 1, go to IDLE. Otherwise hold indefinitely (backpressure).
- Timing:
  - Acceptance at edge N; resp_valid first high in the cycle after edge N+LATENCY.
  - Minimum request-to-request spacing is LATENCY+2 edges: a one-cycle IDLE bubble follows every response. No accept occurs in the same cycle as a response handshake.
- Store commit: the array is written on the WAIT→RESP edge, so a later load always sees the stored data.
- Load data: sampled from the array on the WAIT→RESP edge and registered into resp_rdata. A load response carries resp_rdata = mem[index].
- resp_rdata and resp_err: driven 0 in all states other than RESP.
- req_* inputs: ignored outside IDLE. Their changes after acceptance have no effect.
- Reset mid-operation: the pending request is dropped. A store still in WAIT is not committed. Outputs return to reset values immediately.
- Arithmetic: the counter is 4 bits and never wraps, because it stops at 0. Addresses above the array range never alias.

Decomposition:
- Package dmem_pkg holds:
  - state encoding constants: ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_RESP = 2'd2;
  - DATA_W = 32 and ADDR_W = 32;
  - helper for the index width, log2(DEPTH_WORDS).
- One sub-module, dmem_array: the synchronous word array with async clear on startin, one write port and one registered read port. The FSM and counter stay in dmem_responder.

Test Plan:
- Reset then idle: assert startin mid-cycle -> outputs go to reset values immediately. req_ready = 1, resp_valid = 0, busy = 0 until the first request.
- Store then load, LATENCY = 2:
  - Store addr 0x10, data 0xDEADBEEF accepted at edge 0 -> resp_valid high after edge 2 with resp_err = 0, resp_rdata = 0.
  - Load of 0x10 -> resp_rdata = 0xDEADBEEF.
- Backpressure: hold resp_ready = 0 for 5 cycles on a load of 0x10 -> resp_valid and resp_rdata = 0xDEADBEEF stay stable and req_ready stays 0. Releasing resp_ready gives IDLE next cycle.
- Errors:
  - Load 0x13 -> resp_err = 1, rdata = 0.
  - Store 0x400 with DEPTH_WORDS = 256 -> resp_err = 1, and a subsequent load 0x0 still returns its prior value.
  - Latency is unchanged in both cases.
- Reset mid-WAIT: store 0x20 = 0x12345678, assert startin one cycle after acceptance -> no response; a later load 0x20 returns 0.
- Back-to-back with LATENCY = 1: hold req_valid high continuously -> accepts spaced exactly 3 edges apart, each response correct.
